promedio_sched: RTL and testbench
=================================

// Module: promedio_sched
// PURPOSE
//  Round-robin scheduler that shares one 4-sample averager (en/sum_en/in -> out/sum_ready) among CH sensor channels.
//  Grants one requesting channel, muxes its 16-bit sample onto the averager, waits for sum_ready, captures out.
//  Publishes the result with its channel index, then clears the averager for the next grant.
//  Sits between the per-channel sample sources and the averager instance.
// PARAMETERS
//  CH      4   number of requesting channels (>=2)
//  N       8   averager output width (matches the averager's N)
//  TIMEOUT 15  max RUN cycles without avg_sum_ready before abort (>=6)
// PORTS
//  clk           in   1       clock, rising edge
//  reset         in   1       asynchronous, active-low reset
//  start         in   1       global enable; low = stop and hold IDLE
//  req           in   CH      per-channel request, level, sampled only in IDLE
//  sample_in     in   16*CH   channel k sample at [16k+15:16k]
//  avg_out       in   N       averager result
//  avg_sum_ready in   1       averager sum_ready
//  avg_en        out  1       to averager en
//  avg_sum_en    out  1       to averager sum_en
//  avg_in        out  16      to averager in: selected channel sample, 0 when not RUN
//  grant         out  CH      one-hot granted channel, high in RUN and CAPT
//  res_data      out  N       captured average
//  res_ch        out  clog2(CH)  channel index of res_data
//  res_valid     out  1       1-cycle pulse: res_data/res_ch new
//  busy          out  1       state != IDLE
//  timeout_err   out  1       sticky: a RUN timed out
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; all outputs 0; rr pointer = CH-1 (ch 0 wins first); timeout counter 0.
//  FSM (Moore; avg_en = avg_sum_en = (state==RUN)):
//   IDLE: if start & |req -> RUN; grant = first req set searching from ptr+1 mod CH.
//         The granted index is registered and ptr <= granted index.
//   RUN:  avg_in = sample_in[sel] live every cycle (averager sums 4 consecutive cycles).
//         tcnt counts RUN cycles.
//         avg_sum_ready=1 -> CAPT.
//         start=0 -> IDLE (abort, no result).
//         tcnt==TIMEOUT-1 with no avg_sum_ready -> IDLE, timeout_err<=1, no result.
//   CAPT: avg_sum_en=0 clears the averager. At exit edge: res_data<=avg_out, res_ch<=sel, res_valid<=1. -> IDLE.
//  Timing with a healthy averager: RUN lasts exactly 6 cycles (sum_ready arrives in RUN cycle 6).
//   CAPT is cycle 7; res_valid is high in cycle 8 (the first IDLE cycle).
//   Next grant can enter RUN in cycle 9 -> 8 cycles per result.
//  res_data/res_ch hold until the next capture. res_valid is never high for 2 consecutive cycles.
//  req changes during RUN/CAPT are ignored; a req dropped before IDLE is not served.
//  avg_sum_ready outside RUN is ignored.
//  Two requesters both always high: strict alternation. One requester: served back-to-back.
//  start low in IDLE: no grant, even with req set. start low in CAPT: capture still completes.
//  timeout_err clears only on reset. tcnt clears on entering RUN. Width: clog2(TIMEOUT+1).
//  Reset mid-RUN: outputs drop to 0 immediately. No res_valid. Pointer returns to CH-1.
// TESTING
//  T1 start=1, req=0001, ch0 sample=16'd8 constant, real averager N=8
//     -> grant=0001 for 7 cycles; res_valid in cycle 8; res_data=8; res_ch=0.
//  T2 req=1111 held, 8 grants -> res_ch order 0,1,2,3,0,1,2,3; res_valid every 8 cycles.
//  T3 ch2 samples 4,8,12,16 on consecutive RUN cycles -> res_data=10, res_ch=2.
//  T4 avg_sum_ready tied 0, TIMEOUT=15 -> RUN 15 cycles; then IDLE; timeout_err=1; no res_valid; sticky until reset.
//  T5 start dropped in RUN cycle 3 -> next cycle IDLE, avg_en=0, no res_valid.
//     start re-raised -> next channel in rr order granted.
//  T6 reset=0 asserted asynchronously in RUN cycle 4 -> all outputs 0 before the next clk edge.
//     After release, req=1010 -> ch1 granted first.

Source files
------------

// File: rtl/promedio_sched_if.sv
// Scheduler <-> shared 4-sample averager link.
// The scheduler drives en/sum_en/in; the averager returns out/sum_ready.
interface promedio_sched_if #(
  parameter int N = 8
);
  logic         avg_en;
  logic         avg_sum_en;
  logic [15:0]  avg_in;
  logic [N-1:0] avg_out;
  logic         avg_sum_ready;

  modport master (output avg_en, avg_sum_en, avg_in, input avg_out, avg_sum_ready);
  modport slave  (input avg_en, avg_sum_en, avg_in, output avg_out, avg_sum_ready);
endinterface

// File: rtl/promedio_sched.sv
// Round-robin scheduler sharing one 4-sample averager among CH channels.
// Grants a requester, streams its sample, captures the average and tags it with the channel.
module promedio_sched #(
  parameter int CH      = 4,
  parameter int N       = 8,
  parameter int TIMEOUT = 15,
  localparam int CW     = $clog2(CH),
  localparam int TW     = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CH-1:0]        req,
  input  logic [16*CH-1:0]     sample_in,
  promedio_sched_if.master     avg,
  output logic [CH-1:0]        grant,
  output logic [N-1:0]         res_data,
  output logic [CW-1:0]        res_ch,
  output logic                 res_valid,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {IDLE, RUN, CAPT} state_t;

  state_t              state, nxt;
  logic [CW-1:0]       sel, ptr, pick;
  logic [TW-1:0]       tcnt;
  logic                tmo;
  logic [CH-1:0][15:0] samp;

  assign samp = sample_in;

  // Scan from ptr down to ptr+1 so the nearest requester after ptr wins last.
  always_comb begin : arb
    int c;
    pick = ptr;
    for (int i = CH; i >= 1; i--) begin
      c = int'(ptr) + i;
      if (c >= CH) c = c - CH;
      if (req[CW'(c)]) pick = CW'(c);
    end
  end

  assign tmo = (state == RUN) && start && !avg.avg_sum_ready && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start && |req) nxt = RUN;
      RUN: begin
        if (!start)                  nxt = IDLE;
        else if (avg.avg_sum_ready)  nxt = CAPT;
        else if (tmo)                nxt = IDLE;
      end
      CAPT:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign avg.avg_en     = (state == RUN);
  assign avg.avg_sum_en = (state == RUN);
  assign avg.avg_in     = (state == RUN) ? samp[sel] : 16'd0;
  assign grant          = (state == RUN || state == CAPT) ? (CH'(1) << sel) : '0;
  assign busy           = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel         <= '0;
      ptr         <= CW'(CH - 1);
      tcnt        <= '0;
      res_data    <= '0;
      res_ch      <= '0;
      res_valid   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: if (nxt == RUN) begin
          sel  <= pick;
          ptr  <= pick;
          tcnt <= '0;
        end
        RUN: begin
          tcnt <= tcnt + 1'b1;
          if (tmo) timeout_err <= 1'b1;
        end
        CAPT: begin
          res_data  <= avg.avg_out;
          res_ch    <= sel;
          res_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_promedio_sched.sv
// Bench for promedio_sched: behavioural 4-sample averager, result scoreboard,
// a vector table for arbitration order and hand sequences for abort/timeout/reset.
module tb_promedio_sched;
  localparam int CH = 4, N = 8, TIMEOUT = 15;

  logic                clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [CH-1:0]       req = '0;
  logic [CH-1:0][15:0] samp = '0;
  logic [CH-1:0]       grant;
  logic [N-1:0]        res_data;
  logic [1:0]          res_ch;
  logic                res_valid, busy, timeout_err;

  promedio_sched_if #(.N(N)) avg ();

  promedio_sched #(.CH(CH), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .req(req), .sample_in(samp),
    .avg(avg.master), .grant(grant), .res_data(res_data), .res_ch(res_ch),
    .res_valid(res_valid), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Averager: sums the first 4 enabled samples, then presents sum/4 with sum_ready
  // one cycle later; sum_en low clears it.
  logic [2:0]   acnt;
  logic [17:0]  asum;
  logic         ardy, kill = 1'b0;
  logic [N-1:0] aout;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acnt <= '0; asum <= '0; ardy <= 1'b0; aout <= '0;
    end else if (!avg.avg_sum_en) begin
      acnt <= '0; asum <= '0; ardy <= 1'b0; aout <= '0;
    end else if (avg.avg_en) begin
      if (acnt < 3'd4) begin
        asum <= asum + 18'(avg.avg_in);
        acnt <= acnt + 3'd1;
      end else if (!ardy) begin
        aout <= N'(asum >> 2);
        ardy <= 1'b1;
      end
    end
  end
  assign avg.avg_out       = aout;
  assign avg.avg_sum_ready = ardy & ~kill;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {logic [1:0] ch; logic [N-1:0] data;} exp_t;
  exp_t q[$];

  task automatic push_exp(input logic [1:0] ch, input logic [N-1:0] data);
    exp_t e;
    e.ch = ch; e.data = data;
    q.push_back(e);
  endtask

  logic prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (res_valid) begin
      chk("res_valid_gap", prev_v, 0);
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_res_valid: got ch %0d data %0d, expected no result", res_ch, res_data);
      end else begin
        e = q.pop_front();
        chk("res_ch", res_ch, e.ch);
        chk("res_data", res_data, e.data);
      end
    end
    prev_v = res_valid;
  end

  task automatic wait_res(input string nm, input int budget);
    int k = 0;
    do begin @(negedge clk); k++; end while (!res_valid && k < budget);
    if (!res_valid) begin
      n_chk++; n_fail++;
      $display("FAIL %s: got no res_valid, expected one within %0d cycles", nm, budget);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0; start = 1'b0; req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {logic [3:0] req; logic [CH-1:0][15:0] s; logic [1:0] ch;} vec_t;
  vec_t tbl[16];

  initial begin
    int vals[4];
    int last;
    vals = '{4, 8, 12, 16};

    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < CH; k++) tbl[i].s[k] = 16'(20 * k + 7 * i + 3);
      if (i < 8)       begin tbl[i].req = 4'b1111; tbl[i].ch = 2'(i % 4); end
      else if (i < 11) begin tbl[i].req = 4'b0101; tbl[i].ch = (i == 9) ? 2'd2 : 2'd0; end
      else if (i < 13) begin tbl[i].req = 4'b0010; tbl[i].ch = 2'd1; end
      else if (i < 15) begin tbl[i].req = 4'b1010; tbl[i].ch = (i == 13) ? 2'd3 : 2'd1; end
      else             begin tbl[i].req = 4'b1001; tbl[i].ch = 2'd3; end
    end

    // reset state
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_ch", res_ch, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_avg_en", avg.avg_en, 0);
    chk("rst_avg_sum_en", avg.avg_sum_en, 0);
    chk("rst_avg_in", avg.avg_in, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // T1: single channel, constant sample
    samp[0] = 16'd8; start = 1'b1; req = 4'b0001;
    push_exp(2'd0, 8'd8);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk($sformatf("t1_grant_c%0d", c), grant, 4'b0001);
      chk($sformatf("t1_avg_en_c%0d", c), avg.avg_en, (c <= 6));
      if (c == 7) req = '0;
    end
    @(negedge clk);
    chk("t1_res_valid_c8", res_valid, 1);
    chk("t1_busy_c8", busy, 0);

    // T2 + arbitration table
    reset_dut();
    start = 1'b1;
    req = tbl[0].req; samp = tbl[0].s;
    push_exp(tbl[0].ch, tbl[0].s[tbl[0].ch][7:0]);
    last = 0;
    for (int i = 0; i < 16; i++) begin
      wait_res($sformatf("tbl_%0d", i), 40);
      if (i > 0) chk($sformatf("tbl_period_%0d", i), cyc - last, 8);
      last = cyc;
      if (i < 15) begin
        req = tbl[i+1].req; samp = tbl[i+1].s;
        push_exp(tbl[i+1].ch, tbl[i+1].s[tbl[i+1].ch][7:0]);
      end else req = '0;
    end

    // T3: ch2 samples change every RUN cycle
    samp[0] = 16'd100; samp[1] = 16'd200; samp[2] = 16'd0; samp[3] = 16'd300;
    req = 4'b0100;
    push_exp(2'd2, 8'd10);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) req = '0;
      samp[2] = 16'(vals[k]);
      #1 chk($sformatf("t3_avg_in_%0d", k), avg.avg_in, vals[k]);
    end
    wait_res("t3", 20);

    // T4: averager never answers
    kill = 1'b1;
    req = 4'b0001;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      chk($sformatf("t4_busy_c%0d", c), busy, 1);
      if (c == 2) req = '0;
      if (c == 15) chk("t4_err_before", timeout_err, 0);
    end
    @(negedge clk);
    chk("t4_idle_c16", busy, 0);
    chk("t4_timeout_err", timeout_err, 1);
    kill = 1'b0;
    req = 4'b0010;
    push_exp(2'd1, 8'd200);
    @(negedge clk);
    req = '0;
    wait_res("t4_after", 20);
    chk("t4_err_sticky", timeout_err, 1);

    // T5: start dropped in RUN, then in CAPT
    reset_dut();
    chk("t5_err_cleared", timeout_err, 0);
    start = 1'b1; req = 4'b1111;
    @(negedge clk);
    chk("t5_grant_c1", grant, 4'b0001);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_avg_en", avg.avg_en, 0);
    @(negedge clk);
    chk("t5_no_grant_start_low", grant, 0);
    start = 1'b1;
    push_exp(2'd1, 8'd200);
    @(negedge clk);
    chk("t5_next_rr", grant, 4'b0010);
    repeat (5) @(negedge clk);
    @(negedge clk);
    chk("t5_capt_grant", grant, 4'b0010);
    start = 1'b0;
    wait_res("t5_capt", 4);
    @(negedge clk);
    chk("t5_hold_idle", busy, 0);

    // T6: async reset mid-RUN
    req = 4'b0001; start = 1'b1;
    for (int c = 1; c <= 3; c++) @(negedge clk);
    chk("t6_grant_c3", grant, 4'b0001);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_grant", grant, 0);
    chk("t6_busy", busy, 0);
    chk("t6_avg_en", avg.avg_en, 0);
    chk("t6_avg_in", avg.avg_in, 0);
    chk("t6_res_data", res_data, 0);
    chk("t6_res_ch", res_ch, 0);
    @(negedge clk);
    reset = 1'b1; req = 4'b1010;
    push_exp(2'd1, 8'd200);
    @(negedge clk);
    chk("t6_first_grant", grant, 4'b0010);
    req = '0;
    wait_res("t6", 20);

    repeat (3) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1);
  end

endmodule
